// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spi_pkg
//  Brief    : Shared types and constants for the SPI master block.
//  Revision : 1.0 - initial release
// ============================================================================
package spi_pkg;

    // Master transfer sequencer states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETUP    = 2'd1,
        TRANSFER = 2'd2,
        FINISH   = 2'd3
    } state_t;

    localparam int SPI_DATA_W = 8;

    // SPI mode 0: clock idles low, data sampled on the leading edge
    localparam logic CPOL = 1'b0;
    localparam logic CPHA = 1'b0;

    // Divider counter width (holds CLK_DIV-1 for CLK_DIV up to 255)
    localparam int DIV_W = 8;

    // Bit counter width (counts 8 bits, wraps on the last one)
    localparam int BIT_CNT_W = 3;

endpackage : spi_pkg
`default_nettype wire

// File: rtl/spi_sclk_div.sv
`default_nettype none
// ============================================================================
//  Module   : spi_sclk_div
//  Brief    : sclk divider. Counts CLK_DIV system clocks per half period,
//             produces a terminal-count tick, single-cycle leading/trailing
//             edge strobes and the registered sclk level.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_sclk_div
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,      // high while the serial clock must toggle
    input  logic restart,  // reload the counter (state change)
    output logic tick,     // counter at terminal value this cycle
    output logic rise,     // sclk leaves idle level at the end of this cycle
    output logic fall,     // sclk returns to idle level at the end of this cycle
    output logic sclk
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;

    assign tick = (div_cnt == DIV_LAST);
    assign rise = run & tick & (sclk == CPOL);
    assign fall = run & tick & (sclk != CPOL);

    // Divider counter: reloads on every terminal count and on every state change
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (restart || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Serial clock level: parked at idle outside TRANSFER, toggles on each tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk <= CPOL;
        end else if (!run) begin
            sclk <= CPOL;
        end else if (tick) begin
            sclk <= ~sclk;
        end
    end

endmodule : spi_sclk_div
`default_nettype wire

// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
//  Module   : spi_master
//  Brief    : Single-byte SPI master, mode 0. IDLE -> SETUP -> TRANSFER ->
//             FINISH sequencer with tx/rx shift registers; sclk generation
//             lives in spi_sclk_div.
//             Build option SPI_MASTER_LSB_FIRST_EN: shift LSB first
//             (default build shifts MSB first).
//  Revision : 1.0 - initial release
// ============================================================================
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [SPI_DATA_W-1:0] tx_data,
    output logic                  busy,
    output logic                  done,
    output logic [SPI_DATA_W-1:0] rx_data,
    output logic                  sclk,
    output logic                  cs,
    output logic                  mosi,
    input  logic                  miso
);

    localparam logic [BIT_CNT_W-1:0] BIT_LAST = '1;

    state_t state;
    state_t next_state;

    logic [SPI_DATA_W-1:0] tx_sr;
    logic [SPI_DATA_W-1:0] rx_sr;
    logic [SPI_DATA_W-1:0] tx_next;
    logic [SPI_DATA_W-1:0] rx_next;
    logic [BIT_CNT_W-1:0]  bit_cnt;

    logic run;
    logic restart;
    logic tick;
    logic rise;
    logic fall;
    logic sample_edge;
    logic shift_edge;
    logic accept;
    logic last_shift;
    logic finish_exit;

    assign run     = (state == TRANSFER);
    assign restart = (next_state != state);

    // Mode 0 samples on the leading edge and shifts on the trailing edge
    assign sample_edge = (CPHA == 1'b0) ? rise : fall;
    assign shift_edge  = (CPHA == 1'b0) ? fall : rise;

    // mosi is a shift-register bit, so it is glitch-free and reads 0 whenever
    // the register has been cleared (reset, FINISH)
`ifdef SPI_MASTER_LSB_FIRST_EN
    assign mosi    = tx_sr[0];
    assign tx_next = {1'b0, tx_sr[SPI_DATA_W-1:1]};
    assign rx_next = {miso, rx_sr[SPI_DATA_W-1:1]};
`else
    assign mosi    = tx_sr[SPI_DATA_W-1];
    assign tx_next = {tx_sr[SPI_DATA_W-2:0], 1'b0};
    assign rx_next = {rx_sr[SPI_DATA_W-2:0], miso};
`endif

    spi_sclk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_div (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .restart (restart),
        .tick    (tick),
        .rise    (rise),
        .fall    (fall),
        .sclk    (sclk)
    );

    // Sequencer state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Sequencer next-state decode and single-cycle event strobes
    always_comb begin
        next_state  = state;
        accept      = 1'b0;
        last_shift  = 1'b0;
        finish_exit = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = SETUP;
                end
            end
            SETUP: begin
                if (tick) begin
                    next_state = TRANSFER;
                end
            end
            TRANSFER: begin
                if (shift_edge && (bit_cnt == BIT_LAST)) begin
                    last_shift = 1'b1;
                    next_state = FINISH;
                end
            end
            FINISH: begin
                if (tick) begin
                    finish_exit = 1'b1;
                    next_state  = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Registered status and chip select, decoded from the state being entered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs      <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            rx_data <= '0;
        end else begin
            cs   <= !((next_state == SETUP) || (next_state == TRANSFER));
            busy <= (next_state != IDLE);
            done <= finish_exit;
            if (finish_exit) begin
                rx_data <= rx_sr;
            end
        end
    end

    // Shift registers and bit counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_sr   <= '0;
            rx_sr   <= '0;
            bit_cnt <= '0;
        end else begin
            if (accept) begin
                tx_sr   <= tx_data;
                bit_cnt <= '0;
            end
            if (sample_edge) begin
                rx_sr <= rx_next;
            end
            if (shift_edge) begin
                bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                // The last trailing edge clears tx_sr so mosi parks at 0
                tx_sr   <= last_shift ? '0 : tx_next;
            end
        end
    end

endmodule : spi_master
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_master
//  Brief    : Directed self-checking bench for spi_master. Two instances:
//             CLK_DIV=4 with miso looped back to mosi, and CLK_DIV=1 with
//             miso driven from a fixed pattern that advances on sclk falls.
//             Honours SPI_MASTER_LSB_FIRST_EN for bit-order expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_master;

    logic clk;
    logic rst;

    // CLK_DIV = 4 instance, loopback
    logic       start4, busy4, done4, sclk4, cs4, mosi4, miso4;
    logic [7:0] tx4, rx4;
    // CLK_DIV = 1 instance, pattern-driven miso
    logic       start1, busy1, done1, sclk1, cs1, mosi1, miso1;
    logic [7:0] tx1, rx1;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef SPI_MASTER_LSB_FIRST_EN
    localparam bit LSB_MODE = 1'b1;
`else
    localparam bit LSB_MODE = 1'b0;
`endif

    spi_master #(.CLK_DIV(4)) u_dut4 (
        .clk     (clk),
        .rst     (rst),
        .start   (start4),
        .tx_data (tx4),
        .busy    (busy4),
        .done    (done4),
        .rx_data (rx4),
        .sclk    (sclk4),
        .cs      (cs4),
        .mosi    (mosi4),
        .miso    (miso4)
    );

    spi_master #(.CLK_DIV(1)) u_dut1 (
        .clk     (clk),
        .rst     (rst),
        .start   (start1),
        .tx_data (tx1),
        .busy    (busy1),
        .done    (done1),
        .rx_data (rx1),
        .sclk    (sclk1),
        .cs      (cs1),
        .mosi    (mosi1),
        .miso    (miso1)
    );

    assign miso4 = mosi4;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---- activity monitors (sample 1 ns after the edge) ----
    int         rises4 = 0, dones4 = 0, csfalls4 = 0, gap4 = 0, hi_run4 = 0, xrise4 = 0;
    logic       prev_sclk4 = 1'b0, prev_cs4 = 1'b1, first_mosi4 = 1'b0;
    logic [7:0] bits4 = 8'h00;

    always @(posedge clk) begin
        #1;
        if (!prev_sclk4 && sclk4) begin
            rises4++;
            bits4 = {bits4[6:0], mosi4};
            if (xrise4 == 0) first_mosi4 = mosi4;
            xrise4++;
        end
        if (done4) dones4++;
        if (prev_cs4 && !cs4) begin
            csfalls4++;
            gap4   = hi_run4;
            xrise4 = 0;
        end
        if (cs4) hi_run4++;
        else     hi_run4 = 0;
        prev_sclk4 = sclk4;
        prev_cs4   = cs4;
    end

    logic       prev_sclk1 = 1'b0;
    logic [7:0] bits1      = 8'h00;
    logic [7:0] miso_pat1  = 8'hC3;

    assign miso1 = miso_pat1[7];

    always @(posedge clk) begin
        #1;
        if (!prev_sclk1 && sclk1) bits1 = {bits1[6:0], mosi1};
        if (cs1)                        miso_pat1 = 8'hC3;
        else if (prev_sclk1 && !sclk1)  miso_pat1 = {miso_pat1[6:0], 1'b0};
        prev_sclk1 = sclk1;
    end

    // ---- checking and stimulus helpers ----
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // One CLK_DIV=4 transfer; optional extra start pulse at cycle pulse_at.
    // n returns the number of clock edges from start being driven to done.
    task automatic xfer4(input logic [7:0] data, input int pulse_at, output int n);
        start4 = 1'b1;
        tx4    = data;
        n      = 0;
        while (n < 200) begin
            tick();
            n++;
            if (n == 1) begin
                chk("accept_busy", {31'd0, busy4}, 32'd1);
                chk("accept_cs", {31'd0, cs4}, 32'd0);
                chk("accept_mosi", {31'd0, mosi4}, {31'd0, LSB_MODE ? data[0] : data[7]});
                start4 = 1'b0;
                tx4    = ~data;
            end
            if (pulse_at != 0 && n == pulse_at)     start4 = 1'b1;
            if (pulse_at != 0 && n == pulse_at + 1) start4 = 1'b0;
            if (done4) break;
        end
        chk("done4_seen", {31'd0, done4}, 32'd1);
    endtask

    task automatic xfer1(input logic [7:0] data, output int n);
        start1 = 1'b1;
        tx1    = data;
        n      = 0;
        while (n < 100) begin
            tick();
            n++;
            if (n == 1) begin
                start1 = 1'b0;
                tx1    = ~data;
            end
            if (done1) break;
        end
        chk("done1_seen", {31'd0, done1}, 32'd1);
    endtask

    // ---- directed sequence ----
    initial begin
        int n, s_r, s_d, s_c;
        start4 = 1'b0; tx4 = 8'h00;
        start1 = 1'b0; tx1 = 8'h00;
        rst    = 1'b0;
        #1 rst = 1'b1;
        #1;
        // Asynchronous reset takes effect before any clock edge
        chk("rst_cs",    {31'd0, cs4},   32'd1);
        chk("rst_sclk",  {31'd0, sclk4}, 32'd0);
        chk("rst_mosi",  {31'd0, mosi4}, 32'd0);
        chk("rst_busy",  {31'd0, busy4}, 32'd0);
        chk("rst_done",  {31'd0, done4}, 32'd0);
        chk("rst_rx",    {24'd0, rx4},   32'h00);
        chk("rst_cs1",   {31'd0, cs1},   32'd1);
        chk("rst_sclk1", {31'd0, sclk1}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        tick();
        tick();

        // A5 loopback, CLK_DIV=4: done 73 cycles after start, 8 rises
        s_r = rises4;
        xfer4(8'hA5, 0, n);
        chk("a5_latency", n, 32'd73);
        chk("a5_rx", {24'd0, rx4}, 32'hA5);
        chk("a5_busy_low", {31'd0, busy4}, 32'd0);
        chk("a5_rises", rises4 - s_r, 32'd8);
        chk("a5_mosi_seq", {24'd0, bits4}, 32'hA5);
        tick();
        chk("a5_done_width", {31'd0, done4}, 32'd0);
        chk("a5_cs_idle", {31'd0, cs4}, 32'd1);

        // 55 with a stray start during TRANSFER: ignored, not queued
        s_d = dones4;
        s_c = csfalls4;
        xfer4(8'h55, 20, n);
        chk("p55_rx", {24'd0, rx4}, 32'h55);
        repeat (10) tick();
        chk("p55_dones", dones4 - s_d, 32'd1);
        chk("p55_csfalls", csfalls4 - s_c, 32'd1);

        // start held high: FF then 00 back to back
        s_d = dones4;
        s_c = csfalls4;
        start4 = 1'b1;
        tx4    = 8'hFF;
        n = 0;
        while (n < 200) begin
            tick();
            n++;
            if (done4) break;
        end
        chk("b2b_first_latency", n, 32'd73);
        chk("b2b_first_rx", {24'd0, rx4}, 32'hFF);
        tx4 = 8'h00;
        n = 0;
        while (n < 200) begin
            tick();
            n++;
            if (n == 1) begin
                chk("b2b_rebusy", {31'd0, busy4}, 32'd1);
                chk("b2b_done_width", {31'd0, done4}, 32'd0);
            end
            if (done4) break;
        end
        start4 = 1'b0;
        chk("b2b_second_latency", n, 32'd73);
        chk("b2b_second_rx", {24'd0, rx4}, 32'h00);
        chk("b2b_dones", dones4 - s_d, 32'd2);
        chk("b2b_csfalls", csfalls4 - s_c, 32'd2);
        chk("b2b_cs_gap_ok", {31'd0, (gap4 >= 4)}, 32'd1);
        tick();
        tick();

        // Reset after the 3rd sclk rise: immediate abort, no done
        s_r = rises4;
        s_d = dones4;
        start4 = 1'b1;
        tx4    = 8'hC7;
        n = 0;
        while (n < 200) begin
            tick();
            n++;
            if (n == 1) start4 = 1'b0;
            if (rises4 - s_r == 3) break;
        end
        chk("abort_rises", rises4 - s_r, 32'd3);
        rst = 1'b1;
        #1;
        chk("abort_cs",   {31'd0, cs4},   32'd1);
        chk("abort_sclk", {31'd0, sclk4}, 32'd0);
        chk("abort_busy", {31'd0, busy4}, 32'd0);
        chk("abort_mosi", {31'd0, mosi4}, 32'd0);
        repeat (3) tick();
        rst = 1'b0;
        repeat (5) tick();
        chk("abort_no_done", dones4 - s_d, 32'd0);
        xfer4(8'h81, 0, n);
        chk("after_abort_latency", n, 32'd73);
        chk("after_abort_rx", {24'd0, rx4}, 32'h81);
        tick();

        // CLK_DIV=1: send 3C while the slave returns C3
        xfer1(8'h3C, n);
        chk("d1_latency", n, 32'd19);
        chk("d1_rx", {24'd0, rx1}, 32'hC3);
        chk("d1_mosi_seq", {24'd0, bits1}, 32'h3C);
        chk("d1_busy_low", {31'd0, busy1}, 32'd0);
        tick();

        // 01 loopback: first bit on the wire depends on bit order
        xfer4(8'h01, 0, n);
        chk("b01_first_mosi", {31'd0, first_mosi4}, {31'd0, LSB_MODE});
        chk("b01_rx", {24'd0, rx4}, 32'h01);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_spi_master
`default_nettype wire

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter: CLK_DIV, 4, sclk half-period in clk cycles; legal range 1..255.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 start  input  1  transfer request; sampled only in IDLE.
REQ-005 tx_data  input  8  byte to send; captured in the cycle start is accepted.
REQ-006 busy  output  1  high from the cycle after start acceptance until done.
REQ-007 done  output  1  single-cycle pulse at transfer completion.
REQ-008 rx_data  output  8  last received byte; updated in the done cycle.
REQ-009 sclk  output  1  serial clock; idle low (CPOL=0).
REQ-010 cs  output  1  chip select, active-low; idle high.
REQ-011 mosi  output  1  serial data out.
REQ-012 miso  input  1  serial data in.

Function
REQ-013 The FSM SHALL have states IDLE, SETUP, TRANSFER and FINISH, all registered.
- IDLE to SETUP: start=1.
- SETUP to TRANSFER: after CLK_DIV cycles.
- TRANSFER to FINISH: after the 8th sclk falling edge.
- FINISH to IDLE: after CLK_DIV cycles.
REQ-014 On entry to SETUP: cs=0, busy=1, tx_data latched into the tx shift register, mosi=tx_data[7]; sclk stays low.
REQ-015 In TRANSFER, sclk SHALL toggle every CLK_DIV cycles, starting with a rising edge, for exactly 8 rising and 8 falling edges (mode 0).
REQ-016 On each internal sclk rising edge, miso SHALL be shifted into the rx shift register (MSB first).
REQ-017 On each of the first 7 sclk falling edges, mosi SHALL advance to the next tx bit.
REQ-018 A 3-bit bit counter SHALL increment on each falling edge; the 8th falling edge wraps it to 0 and ends TRANSFER.
REQ-019 On entry to FINISH, cs SHALL return to 1, sclk SHALL be 0 and mosi SHALL be 0; cs stays high for at least CLK_DIV cycles.
REQ-020 Leaving FINISH, the block SHALL assert done=1 for one cycle, set busy=0 and load rx_data, all in the same cycle.
REQ-021 done SHALL rise exactly 1+18*CLK_DIV cycles after the cycle in which start is accepted.
REQ-022 start asserted while busy=1 SHALL be ignored; it is not queued.
REQ-023 start held high through the done cycle SHALL begin a new transfer: SETUP is entered on the cycle after done.
REQ-024 Changes to tx_data after acceptance SHALL NOT affect the byte in flight.
REQ-025 The divider counter SHALL be 8 bits wide and SHALL reload to 0 on every sclk toggle and every state change.

Reset
REQ-026 rst=1 SHALL immediately force:
- state = IDLE, cs = 1, sclk = 0, mosi = 0;
- busy = 0, done = 0, rx_data = 8'h00;
- all counters and shift registers to 0.
REQ-027 rst asserted mid-transfer SHALL abort with no done pulse; after release the block accepts start normally.

Configuration
REQ-028 With SPI_MASTER_LSB_FIRST_EN defined, the block SHALL transmit and receive LSB first:
- mosi starts at tx_data[0];
- rx bits shift in from the MSB side.
REQ-029 With SPI_MASTER_LSB_FIRST_EN undefined, the block SHALL transfer MSB first as in REQ-014 to REQ-017.

Structure
REQ-030 Package spi_pkg SHALL hold:
- the master state_t enum (2 bits);
- constant SPI_DATA_W = 8;
- mode constant CPOL = 0, CPHA = 0.
REQ-031 Sub-module spi_sclk_div SHALL hold the divider counter and produce single-cycle rise/fall strobes plus the sclk level; the FSM and shift registers stay in spi_master.

Verification
REQ-032 CLK_DIV=4, tx_data=8'hA5, miso looped to mosi:
- rx_data=8'hA5;
- done 73 cycles after start;
- exactly 8 sclk rising edges.
REQ-033 CLK_DIV=1, tx_data=8'h3C, bench drives miso from 8'hC3 changing on falling edges:
- rx_data=8'hC3;
- mosi bit sequence 0,0,1,1,1,1,0,0.
REQ-034 start pulsed during TRANSFER of 8'h55:
- only one done pulse;
- cs toggles low exactly once.
REQ-035 start held high, tx_data=8'hFF then 8'h00:
- two back-to-back transfers;
- cs high for at least CLK_DIV cycles between them.
REQ-036 rst asserted after the 3rd sclk rise:
- cs=1 and sclk=0 immediately, with no done pulse;
- a following transfer of 8'h81 completes correctly.
REQ-037 With SPI_MASTER_LSB_FIRST_EN defined, tx_data=8'h01:
- mosi=1 on the first rising edge;
- loopback rx_data=8'h01.
